reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, meaning the number of write requesters; requester 0 is the pipeline writeback.
REQ-002 The block SHALL have parameter MAX_WAIT, default 4, meaning the wait cycles after which a requester other than 0 forces an override.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port req_valid, input, NUM_REQ bits: per-requester write request.
REQ-006 Port req_id, input, NUM_REQ x reg_id_t (5 bits each): per-requester destination register.
REQ-007 Port req_data, input, NUM_REQ x op_t (32 bits each): per-requester write data.
REQ-008 Port req_ready, output, NUM_REQ bits: one-hot (or zero) accept.
REQ-009 Port enable_write, output, 1 bit: register-file write enable.
REQ-010 Port write_id, output, reg_id_t: register-file write address.
REQ-011 Port write_data, output, op_t: register-file write data.
REQ-012 Port grant_idx, output, 2 bits: index of the last accepted requester.
REQ-013 Port starve_active, output, 1 bit: the block is in OVERRIDE state.
REQ-014 Port stall_count, output, 16 bits: saturating count of stalled writeback cycles.

Function
REQ-015 At most one req_ready bit SHALL be high per cycle.
- req_ready is combinational from req_valid and the current state.
- A transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-016 Requesters SHALL hold req_id and req_data stable while req_valid is high and req_ready is low; the block does not buffer unaccepted requests.
REQ-017 The write port SHALL be registered with 1-cycle latency: a transfer in cycle N drives enable_write, write_id and write_data in cycle N+1.
- If no transfer occurs, enable_write=0 and write_id/write_data hold their previous values.
REQ-018 A transfer with req_id=0 SHALL be accepted, but enable_write SHALL stay 0 in the following cycle.
REQ-019 In NORMAL state, granting SHALL follow these rules:
- Requester 0 wins whenever it is valid.
- Otherwise, round-robin applies among requesters 1..NUM_REQ-1, starting at the index after rr_ptr.
- rr_ptr updates to the granted index on each non-zero grant.
REQ-020 Each requester i>=1 SHALL have a wait counter with these rules:
- Increments when req_valid[i] is high and it is not granted.
- Saturates at MAX_WAIT.
- Clears to 0 when granted or when req_valid[i] is low.
REQ-021 The state machine SHALL be NORMAL -> OVERRIDE at the clock edge when any wait counter reaches MAX_WAIT.
REQ-022 In OVERRIDE, the block SHALL grant the lowest-index saturated requester, even if requester 0 is valid.
- It returns to NORMAL after that grant if no other counter is saturated; otherwise it stays in OVERRIDE.
REQ-023 If the saturated requester drops req_valid while in OVERRIDE, the block SHALL return to NORMAL with no grant that cycle.
REQ-024 stall_count SHALL increment each cycle in which req_valid[0]=1 and req_ready[0]=0, saturating at 0xFFFF, with no wrap.
REQ-025 grant_idx SHALL update at the same edge as the write-port registers, and only on a transfer.

Reset
REQ-026 While rst=1, the block SHALL reset as follows:
- Outputs: enable_write=0, write_id=0, write_data=0, grant_idx=0, starve_active=0, stall_count=0; req_ready all 0.
- Internal state: NORMAL, all wait counters 0, rr_ptr=NUM_REQ-1 (so the first round-robin grant goes to requester 1).
REQ-027 Reset asserted mid-operation SHALL discard a pending registered write, so no enable_write pulse follows reset release.
- The first grant is possible in the first cycle after rst deasserts.

Structure
REQ-028 arb_state_t (NORMAL, OVERRIDE) and the defaults for NUM_REQ and MAX_WAIT SHALL live in the shared Parameters/Types packages; reg_id_t and op_t are reused from Types.
REQ-029 The round-robin selection SHALL be a sub-module rr_pick.
- Inputs: request mask, pointer.
- Outputs: grant one-hot, index.
- Purely combinational.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Single write: req0 valid, id=5, data=0x1234 in cycle 1 -> req_ready[0]=1 in cycle 1; enable_write=1, write_id=5, write_data=0x1234 in cycle 2.
- x0 write: req1 valid, id=0, data=0xFFFF_FFFF -> req_ready[1]=1; enable_write stays 0 the next cycle.
- Round-robin: req1 and req2 held valid, req0 idle -> grants alternate 1,2,1,2; rr_ptr wraps from 2 back to 1.
- Starvation: req0 and req1 held valid continuously with MAX_WAIT=4 -> req1 granted in cycle 6 (4 waits plus entry to OVERRIDE), starve_active=1 that cycle, then req0 again.
- Stall counter: req0 blocked by override 3 times -> stall_count=3; with the counter preloaded near 0xFFFF and more stalls, it holds at 0xFFFF.
- Reset mid-operation: rst asserted in the cycle of a req0 transfer -> enable_write=0 after release; the state is NORMAL and all counters are 0.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and default sizing for the register-file write arbiter.
package reg_write_arbiter_pkg;

    localparam int unsigned NumReqDefault  = 3;
    localparam int unsigned MaxWaitDefault = 4;
    localparam int unsigned RegIdW         = 5;
    localparam int unsigned OpW            = 32;

    typedef logic [RegIdW-1:0] reg_id_t;
    typedef logic [OpW-1:0]    op_t;

    typedef enum logic [0:0] {
        StNormal,
        StOverride
    } arb_state_t;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit strictly after ptr, wrapping.
module rr_pick #(
    parameter  int unsigned N    = 3,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_mask,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IdxW'((32'(ptr) + k) % N);
            if (!found && req_mask[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: writeback priority, round-robin for the rest,
// with a starvation override once a requester has waited MAX_WAIT cycles.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NumReqDefault,
    parameter int unsigned MAX_WAIT = MaxWaitDefault
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  reg_id_t            req_id [NUM_REQ],
    input  op_t                req_data [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output logic               enable_write,
    output reg_id_t            write_id,
    output op_t                write_data,
    output logic [1:0]         grant_idx,
    output logic               starve_active,
    output logic [15:0]        stall_count
);

    localparam int unsigned      IdxW    = $clog2(NUM_REQ);
    localparam int unsigned      WaitW   = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    arb_state_t         state_q, state_d;
    logic [IdxW-1:0]    rr_ptr_q;
    logic [WaitW-1:0]   wait_q [NUM_REQ];
    logic [WaitW-1:0]   wait_d [NUM_REQ];
    logic [15:0]        stall_q;

    logic [NUM_REQ-1:0] rr_mask, rr_gnt, ready, sat, sat_hold;
    logic [IdxW-1:0]    rr_idx, ovr_idx, grant_sel;
    logic               ovr_found, xfer;

    always_comb begin
        rr_mask    = req_valid;
        rr_mask[0] = 1'b0;
    end

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req_mask (rr_mask),
        .ptr      (rr_ptr_q),
        .gnt      (rr_gnt),
        .idx      (rr_idx)
    );

    // Requester 0 never has a wait counter, so it can never be saturated.
    always_comb begin
        sat       = '0;
        ovr_found = 1'b0;
        ovr_idx   = '0;
        for (int unsigned i = 1; i < NUM_REQ; i++) begin
            sat[i] = (wait_q[i] == WaitMax);
        end
        for (int unsigned i = NUM_REQ - 1; i >= 1; i--) begin
            if (sat[i]) begin
                ovr_found = 1'b1;
                ovr_idx   = IdxW'(i);
            end
        end
    end

    always_comb begin
        ready     = '0;
        grant_sel = '0;
        unique case (state_q)
            StNormal: begin
                if (req_valid[0]) begin
                    ready[0] = 1'b1;
                end else begin
                    ready     = rr_gnt;
                    grant_sel = rr_idx;
                end
            end
            StOverride: begin
                if (ovr_found && req_valid[ovr_idx]) begin
                    ready[ovr_idx] = 1'b1;
                    grant_sel      = ovr_idx;
                end
            end
            default: ;
        endcase
        if (rst) begin
            ready = '0;
        end
    end

    assign req_ready = ready;
    assign xfer      = |ready;

    // sat_hold: already saturated and still waiting after this cycle.
    always_comb begin
        sat_hold = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = '0;
            if (i != 0 && req_valid[i] && !ready[i]) begin
                wait_d[i] = (wait_q[i] == WaitMax) ? WaitMax : wait_q[i] + WaitW'(1);
            end
            sat_hold[i] = sat[i] && (wait_d[i] == WaitMax);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StNormal: begin
                if (|sat_hold) state_d = StOverride;
            end
            StOverride: begin
                if (xfer && |sat_hold) state_d = StOverride;
                else                   state_d = StNormal;
            end
            default: state_d = StNormal;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StNormal;
            rr_ptr_q     <= IdxW'(NUM_REQ - 1);
            enable_write <= 1'b0;
            write_id     <= '0;
            write_data   <= '0;
            grant_idx    <= '0;
            stall_q      <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
            // Writes to x0 are accepted but never reach the register file.
            enable_write <= xfer && (req_id[grant_sel] != '0);
            if (xfer) begin
                write_id   <= req_id[grant_sel];
                write_data <= req_data[grant_sel];
                grant_idx  <= 2'(grant_sel);
            end
            if (xfer && grant_sel != '0) begin
                rr_ptr_q <= grant_sel;
            end
            if (req_valid[0] && !ready[0] && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign starve_active = (state_q == StOverride);
    assign stall_count   = stall_q;

endmodule
